// File: rtl/mult_bank_pkg.sv
// Shared types and defaults for the multiplier-bank scheduler: the operand and latency defaults,
// the requester-ID width helper and the {valid, id} tag carried alongside each in-flight product.
package mult_bank_pkg;

  localparam int DATA_W_DEF       = 16;
  localparam int MULT_LATENCY_DEF = 3;
  localparam int MAX_REQ          = 8;
  localparam int MAX_ID_W         = 3;

  // A single requester still needs a one-bit ID so that buses never collapse to zero width.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_bank_sched_if.sv
// Requester, bank and response signals of the scheduler, bundled into one interface.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface mult_bank_sched_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = mult_bank_pkg::DATA_W_DEF,
  parameter int MULT_LATENCY = mult_bank_pkg::MULT_LATENCY_DEF
);
  localparam int ID_W  = mult_bank_pkg::id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MULT_LATENCY + 2) + 1;

  logic                        enable;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*DATA_W-1:0]   req_a;
  logic [NUM_REQ*DATA_W-1:0]   req_b;
  logic                        mul_valid;
  logic [DATA_W-1:0]           mul_a;
  logic [DATA_W-1:0]           mul_b;
  logic [2*DATA_W-1:0]         mul_p;
  logic                        rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic [2*DATA_W-1:0]         rsp_data;
  logic [CNT_W-1:0]            inflight;
  logic                        idle;

  modport slave (
    input  enable, req_valid, req_a, req_b, mul_p,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, inflight, idle
  );

  modport master (
    output enable, req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, inflight, idle
  );

endinterface

// File: rtl/mb_rr_arbiter.sv
// Combinational round-robin pick: the first valid requester found searching upward from rr_ptr,
// with modulo wrap. There is no latency. No grant is given while enable is low.
module mb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = mult_bank_pkg::id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    int              s;
    gnt     = '0;
    gnt_idx = rr_ptr;
    found   = 1'b0;
    idx     = '0;
    s       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = ID_W'(s);
      if (enable && !found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mult_bank_sched.sv
// Round-robin front end for a shared pipelined multiplier, with MULT_LATENCY+2 cycles from accept to response.
// It accepts at most one operand pair per cycle; the response port has no backpressure.
module mult_bank_sched
  import mult_bank_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  mult_bank_sched_if.slave  bus
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MULT_LATENCY + 2) + 1;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                xfer;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic                mul_valid_q, mul_valid_d;
  logic [DATA_W-1:0]   mul_a_q,     mul_a_d;
  logic [DATA_W-1:0]   mul_b_q,     mul_b_d;
  logic [ID_W-1:0]     mul_id_q,    mul_id_d;
  tag_t                tag_q [MULT_LATENCY];
  tag_t                tag_d [MULT_LATENCY];
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [2*DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [CNT_W-1:0]    inflight_q,  inflight_d;

  mb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr_q),
    .enable  (bus.enable),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign xfer = |gnt;

  // The grant is one-hot, so an AND-OR mux selects the granted operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = sel_a | bus.req_a[i*DATA_W +: DATA_W];
        sel_b = sel_b | bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mul_valid_d = xfer;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_id_d    = mul_id_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      mul_a_d  = sel_a;
      mul_b_d  = sel_b;
      mul_id_d = gnt_idx;
    end
  end

  // The tag pipeline shifts every cycle, so the last stage lines up with the bank output.
  always_comb begin
    tag_d[0].vld = mul_valid_q;
    tag_d[0].id  = MAX_ID_W'(mul_id_q);
    for (int i = 1; i < MULT_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = tag_q[MULT_LATENCY-1].vld;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (tag_q[MULT_LATENCY-1].vld) begin
      rsp_id_d   = tag_q[MULT_LATENCY-1].id[ID_W-1:0];
      rsp_data_d = bus.mul_p;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({xfer, rsp_valid_q})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr_q    <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_id_q    <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_id_q    <= mul_id_d;
      for (int i = 0; i < MULT_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.mul_valid = mul_valid_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.inflight  = inflight_q;
  assign bus.idle      = (inflight_q == '0);

endmodule

// File: tb/tb_mult_bank_sched.sv
// Randomized scoreboard bench for mult_bank_sched with a behavioural multiplier bank.
// Expected grants and responses come from a round-robin reference model kept in the bench.
module tb_mult_bank_sched;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int LAT = 3;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          acc;
    int          due;
  } exp_t;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;
  int   cyc    = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rr_model    = 0;
  exp_t sb [$];

  mult_bank_sched_if #(.NUM_REQ(NR), .DATA_W(DW), .MULT_LATENCY(LAT)) bus ();

  mult_bank_sched #(.NUM_REQ(NR), .DATA_W(DW), .MULT_LATENCY(LAT)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus.slave)
  );

  initial forever #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // The bank model is deliberately never reset, so stale products keep arriving after a reset.
  logic [2*DW-1:0] bank_p [LAT];
  always @(posedge ACLK) begin
    bank_p[0] <= {16'b0, bus.mul_a} * {16'b0, bus.mul_b};
    for (int i = 1; i < LAT; i++) bank_p[i] <= bank_p[i-1];
  end
  assign bus.mul_p = bank_p[LAT-1];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [NR*DW-1:0] rand_ops();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = 16'($urandom);
    return r;
  endfunction

  // One cycle: apply the inputs, check the grant against the model, and queue the expected response.
  task automatic drive(input logic en, input logic [NR-1:0] v,
                       input logic [NR*DW-1:0] a, input logic [NR*DW-1:0] b);
    int          idx;
    logic [NR-1:0] g;
    exp_t        e;
    bus.enable    = en;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge ACLK);
    idx = -1;
    g   = '0;
    if (en) begin
      for (int k = 0; k < NR; k++) begin
        if (idx < 0 && v[(rr_model + k) % NR]) idx = (rr_model + k) % NR;
      end
    end
    if (idx >= 0) g[idx] = 1'b1;
    chk("req_ready", bus.req_ready, g);
    if (idx >= 0) begin
      e.id   = idx;
      e.data = {16'b0, a[idx*DW +: DW]} * {16'b0, b[idx*DW +: DW]};
      e.acc  = cyc;
      e.due  = cyc + LAT + 2;
      sb.push_back(e);
      rr_model = (idx + 1) % NR;
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      drive(1'b0, '0, '0, '0);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) drive(1'b0, '0, '0, '0);
  endtask

  task automatic check_reset_values();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mul_valid", bus.mul_valid, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_idle", bus.idle, 1);
  endtask

  // Monitor: in-flight accounting and response ordering, decoupled from the stimulus.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      int   exp_inf;
      exp_t e;
      exp_inf = 0;
      foreach (sb[i]) if (sb[i].acc < cyc) exp_inf++;
      chk("inflight", bus.inflight, exp_inf);
      chk("idle", bus.idle, (exp_inf == 0));
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk("rsp_late", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*DW-1:0] a, b;
    bus.enable    = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_values();
    ARESET = 1'b0;

    // All four valid for 8 cycles: 0,1,2,3,0,1,2,3
    repeat (8) drive(1'b1, 4'hF, rand_ops(), rand_ops());
    drain();

    // Single request from requester 2: 3 x 7
    a = '0; b = '0;
    a[2*DW +: DW] = 16'd3;
    b[2*DW +: DW] = 16'd7;
    drive(1'b1, 4'b0100, a, b);
    drain();

    // Requester 1 alone moves the pointer to 2; then {1,3} must wrap: 3 first, then 1
    drive(1'b1, 4'b0010, rand_ops(), rand_ops());
    drive(1'b1, 4'b1010, rand_ops(), rand_ops());
    drive(1'b1, 4'b1010, rand_ops(), rand_ops());
    drain();

    // Enable drops after 2 transfers while requests stay valid
    drive(1'b1, 4'hF, rand_ops(), rand_ops());
    drive(1'b1, 4'hF, rand_ops(), rand_ops());
    repeat (6) drive(1'b0, 4'hF, rand_ops(), rand_ops());
    drain();

    // Boundary operands under sustained load: accept and response in the same cycle
    a = '1; b = '1;
    repeat (10) drive(1'b1, 4'hF, a, b);
    drain();

    // Random traffic
    repeat (300) drive(($urandom_range(0, 9) != 0), 4'($urandom), rand_ops(), rand_ops());
    drain();

    // Reset with 3 operations in flight
    repeat (3) drive(1'b1, 4'hF, rand_ops(), rand_ops());
    bus.enable    = 1'b0;
    bus.req_valid = '0;
    ARESET        = 1'b1;
    sb.delete();
    rr_model = 0;
    #1;
    check_reset_values();
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (10) drive(1'b0, '0, '0, '0);
    // Pointer restarts at 0 after reset
    repeat (4) drive(1'b1, 4'hF, rand_ops(), rand_ops());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
